// File: rtl/ac97_status_rx_if.sv
// AC-link receive-side bundle: serial SYNC/SDATA_IN in, deframed status/PCM results out.
// Optional AC97_FRAME_ERR_EN adds frame_error and frame_count.
interface ac97_status_rx_if #(
  parameter int unsigned PCM_WIDTH = 20
);
  logic                 sync;
  logic                 sdata_in;
  logic                 codec_ready;
  logic [7:0]           status_address;
  logic [15:0]          status_data;
  logic                 status_valid;
  logic [PCM_WIDTH-1:0] left_in_data;
  logic [PCM_WIDTH-1:0] right_in_data;
  logic                 pcm_valid;
  logic                 frame_ready;
`ifdef AC97_FRAME_ERR_EN
  logic                 frame_error;
  logic [7:0]           frame_count;
`endif

  // Deframer side.
  modport slave (
    input  sync,
    input  sdata_in,
    output codec_ready,
    output status_address,
    output status_data,
    output status_valid,
    output left_in_data,
    output right_in_data,
    output pcm_valid,
    output frame_ready
`ifdef AC97_FRAME_ERR_EN
    ,
    output frame_error,
    output frame_count
`endif
  );

  // Link/consumer side.
  modport master (
    output sync,
    output sdata_in,
    input  codec_ready,
    input  status_address,
    input  status_data,
    input  status_valid,
    input  left_in_data,
    input  right_in_data,
    input  pcm_valid,
    input  frame_ready
`ifdef AC97_FRAME_ERR_EN
    ,
    input  frame_error,
    input  frame_count
`endif
  );
endinterface

// File: rtl/ac97_status_rx.sv
// AC-link SDATA_IN deframer. Frames on the SYNC rising edge, captures the tag, slot 1/2 status
// and slot 3/4 record PCM, and emits one-cycle valid strobes plus a per-frame frame_ready.
// Optional AC97_FRAME_ERR_EN adds sticky frame_error and a saturating frame_count.
module ac97_status_rx #(
  parameter int unsigned FRAME_BITS = 256,
  parameter int unsigned PCM_WIDTH  = 20
) (
  input logic             clock,
  input logic             reset_n,
  ac97_status_rx_if.slave bus
);
  localparam int unsigned CntW = $clog2(FRAME_BITS);
  localparam logic [CntW-1:0] LastBit     = CntW'(FRAME_BITS - 1);
  localparam logic [CntW-1:0] BitTagEnd   = CntW'(15);
  localparam logic [CntW-1:0] BitSlot1End = CntW'(35);
  localparam logic [CntW-1:0] BitSlot2End = CntW'(55);
  localparam logic [CntW-1:0] BitSlot3End = CntW'(75);
  localparam logic [CntW-1:0] BitSlot4End = CntW'(95);

  typedef enum logic [2:0] {
    StIdle, StTag, StSlot1, StSlot2, StSlot3, StSlot4, StDrain
  } state_e;

  // Slot that contains frame bit b.
  function automatic state_e slot_of(input logic [CntW-1:0] b);
    if (b <= BitTagEnd)        return StTag;
    else if (b <= BitSlot1End) return StSlot1;
    else if (b <= BitSlot2End) return StSlot2;
    else if (b <= BitSlot3End) return StSlot3;
    else if (b <= BitSlot4End) return StSlot4;
    else                       return StDrain;
  endfunction

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;  // frame bit index of the sample being taken this cycle
  logic [19:0]           shift_q, shift_d;
  logic                  sync_dly_q, sync_dly_d;
  logic [3:0]            tag_flags_q, tag_flags_d;  // tag[14:11]: slot 1..4 valid
  logic [6:0]            slot1_idx_q, slot1_idx_d;
  logic [PCM_WIDTH-1:0]  slot3_q, slot3_d;
  logic                  codec_ready_q, codec_ready_d;
  logic [7:0]            status_address_q, status_address_d;
  logic [15:0]           status_data_q, status_data_d;
  logic                  status_valid_q, status_valid_d;
  logic [PCM_WIDTH-1:0]  left_q, left_d;
  logic [PCM_WIDTH-1:0]  right_q, right_d;
  logic                  pcm_valid_q, pcm_valid_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  frame_start, active;
  logic [CntW-1:0]       cur_bit;

  // Next-state: framing counter, slot captures and strobes.
  always_comb begin
    frame_start      = bus.sync & ~sync_dly_q;
    active           = (state_q != StIdle);
    // A frame start always makes this sample bit 0, abandoning any partial frame.
    cur_bit          = frame_start ? '0 : cnt_q;
    sync_dly_d       = bus.sync;
    shift_d          = {shift_q[18:0], bus.sdata_in};
    state_d          = StIdle;
    cnt_d            = '0;
    tag_flags_d      = tag_flags_q;
    slot1_idx_d      = slot1_idx_q;
    slot3_d          = slot3_q;
    codec_ready_d    = codec_ready_q;
    status_address_d = status_address_q;
    status_data_d    = status_data_q;
    status_valid_d   = 1'b0;
    left_d           = left_q;
    right_d          = right_q;
    pcm_valid_d      = 1'b0;
    frame_ready_d    = 1'b0;
    if (frame_start || active) begin
      cnt_d         = (cur_bit == LastBit) ? '0 : cur_bit + CntW'(1);
      state_d       = slot_of(cnt_d);
      frame_ready_d = (cnt_d == LastBit);
      if (cur_bit == BitTagEnd) begin
        codec_ready_d = shift_d[15];
        tag_flags_d   = shift_d[14:11];
      end
      if (cur_bit == BitSlot1End) slot1_idx_d = shift_d[18:12];
      if (cur_bit == BitSlot2End && tag_flags_q[3] && tag_flags_q[2]) begin
        status_address_d = {1'b0, slot1_idx_q};
        status_data_d    = shift_d[19:4];
        status_valid_d   = 1'b1;
      end
      if (cur_bit == BitSlot3End) slot3_d = shift_d[19 -: PCM_WIDTH];
      if (cur_bit == BitSlot4End && (tag_flags_q[1] || tag_flags_q[0])) begin
        left_d      = slot3_q;
        right_d     = shift_d[19 -: PCM_WIDTH];
        pcm_valid_d = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      shift_q          <= '0;
      sync_dly_q       <= 1'b0;
      tag_flags_q      <= '0;
      slot1_idx_q      <= '0;
      slot3_q          <= '0;
      codec_ready_q    <= 1'b0;
      status_address_q <= '0;
      status_data_q    <= '0;
      status_valid_q   <= 1'b0;
      left_q           <= '0;
      right_q          <= '0;
      pcm_valid_q      <= 1'b0;
      frame_ready_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      shift_q          <= shift_d;
      sync_dly_q       <= sync_dly_d;
      tag_flags_q      <= tag_flags_d;
      slot1_idx_q      <= slot1_idx_d;
      slot3_q          <= slot3_d;
      codec_ready_q    <= codec_ready_d;
      status_address_q <= status_address_d;
      status_data_q    <= status_data_d;
      status_valid_q   <= status_valid_d;
      left_q           <= left_d;
      right_q          <= right_d;
      pcm_valid_q      <= pcm_valid_d;
      frame_ready_q    <= frame_ready_d;
    end
  end

  assign bus.codec_ready    = codec_ready_q;
  assign bus.status_address = status_address_q;
  assign bus.status_data    = status_data_q;
  assign bus.status_valid   = status_valid_q;
  assign bus.left_in_data   = left_q;
  assign bus.right_in_data  = right_q;
  assign bus.pcm_valid      = pcm_valid_q;
  assign bus.frame_ready    = frame_ready_q;

`ifdef AC97_FRAME_ERR_EN
  logic       frame_error_q, frame_error_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Sticky error on early start or on a wrap without a new start; saturating frame count.
  always_comb begin
    frame_error_d = frame_error_q;
    frame_count_d = frame_count_q;
    // cnt_q == 0 while active means bit 255 was just consumed.
    if ((frame_start && active && cnt_q != '0) || (!frame_start && active && cnt_q == '0)) begin
      frame_error_d = 1'b1;
    end
    if ((frame_start || active) && cur_bit == LastBit && frame_count_q != 8'hFF) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Error/count registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.frame_error = frame_error_q;
  assign bus.frame_count = frame_count_q;
`endif
endmodule
